// File: rtl/noisy_sig_gen_if.sv
// Control and sample bus for the noisy tone generator.
// The master drives the generator controls; the slave (the generator) returns samples.
interface noisy_sig_gen_if;
  logic        en;
  logic [15:0] tone_fcw;
  logic        noise_en;
  logic [2:0]  noise_shift;
  logic        signal_valid;
  logic [15:0] noisy_signal;

  modport master (
    output en, tone_fcw, noise_en, noise_shift,
    input  signal_valid, noisy_signal
  );

  modport slave (
    input  en, tone_fcw, noise_en, noise_shift,
    output signal_valid, noisy_signal
  );
endinterface

// File: rtl/noisy_sig_gen.sv
// Quarter-wave table sine tone plus scaled Galois-LFSR noise, saturated to 1.1.14.
// Capture stage, then term stage, then saturated-sum stage; each loads only when its valid is set.
module noisy_sig_gen (
  input  logic             clk,
  input  logic             rst_n,
  noisy_sig_gen_if.slave   bus
);

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrMask = 16'hB400;

  // round(8192 * sin(2*pi*n/256)), n = 0..64
  function automatic logic [13:0] sine_lut(input logic [6:0] idx);
    case (idx)
      7'd0:  return 14'd0;    7'd1:  return 14'd201;  7'd2:  return 14'd402;  7'd3:  return 14'd603;
      7'd4:  return 14'd803;  7'd5:  return 14'd1003; 7'd6:  return 14'd1202; 7'd7:  return 14'd1401;
      7'd8:  return 14'd1598; 7'd9:  return 14'd1795; 7'd10: return 14'd1990; 7'd11: return 14'd2185;
      7'd12: return 14'd2378; 7'd13: return 14'd2570; 7'd14: return 14'd2760; 7'd15: return 14'd2948;
      7'd16: return 14'd3135; 7'd17: return 14'd3320; 7'd18: return 14'd3503; 7'd19: return 14'd3683;
      7'd20: return 14'd3862; 7'd21: return 14'd4038; 7'd22: return 14'd4212; 7'd23: return 14'd4383;
      7'd24: return 14'd4551; 7'd25: return 14'd4717; 7'd26: return 14'd4880; 7'd27: return 14'd5040;
      7'd28: return 14'd5197; 7'd29: return 14'd5351; 7'd30: return 14'd5501; 7'd31: return 14'd5649;
      7'd32: return 14'd5793; 7'd33: return 14'd5933; 7'd34: return 14'd6070; 7'd35: return 14'd6203;
      7'd36: return 14'd6333; 7'd37: return 14'd6458; 7'd38: return 14'd6580; 7'd39: return 14'd6698;
      7'd40: return 14'd6811; 7'd41: return 14'd6921; 7'd42: return 14'd7027; 7'd43: return 14'd7128;
      7'd44: return 14'd7225; 7'd45: return 14'd7317; 7'd46: return 14'd7405; 7'd47: return 14'd7489;
      7'd48: return 14'd7568; 7'd49: return 14'd7643; 7'd50: return 14'd7713; 7'd51: return 14'd7779;
      7'd52: return 14'd7839; 7'd53: return 14'd7895; 7'd54: return 14'd7946; 7'd55: return 14'd7993;
      7'd56: return 14'd8035; 7'd57: return 14'd8071; 7'd58: return 14'd8103; 7'd59: return 14'd8130;
      7'd60: return 14'd8153; 7'd61: return 14'd8170; 7'd62: return 14'd8182; 7'd63: return 14'd8190;
      7'd64: return 14'd8192;
      default: return 14'd0;
    endcase
  endfunction

  logic [15:0]        phase_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_next;

  // Capture stage: the phase/LFSR/noise controls as seen at the en edge.
  logic               s0_valid_q;
  logic [7:0]         k_q;
  logic signed [15:0] lfsr_s_q;
  logic               n_en_q;
  logic [2:0]         shift_q;

  logic               s1_valid_q;
  logic signed [15:0] sine_q;
  logic signed [15:0] noise_q;

  logic               valid_q;
  logic [15:0]        out_q;

  logic [6:0]         idx;
  logic [13:0]        mag;
  logic signed [15:0] mag_s;
  logic signed [15:0] sine_d;
  logic [3:0]         shamt;
  logic signed [15:0] noise_d;
  logic [16:0]        sum;
  logic [15:0]        sat_d;

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

    // Odd quadrants run the quarter table backwards, the lower half-turn is negated.
    idx    = k_q[6] ? (7'd64 - {1'b0, k_q[5:0]}) : {1'b0, k_q[5:0]};
    mag    = sine_lut(idx);
    mag_s  = signed'({2'b00, mag});
    sine_d = k_q[7] ? -mag_s : mag_s;

    shamt   = {1'b0, shift_q} + 4'd2;
    noise_d = n_en_q ? (lfsr_s_q >>> shamt) : 16'sd0;

    sum = {sine_q[15], sine_q} + {noise_q[15], noise_q};
    if (sum[16] != sum[15]) begin
      sat_d = sum[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_d = sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 16'h0000;
      lfsr_q     <= LfsrSeed;
      s0_valid_q <= 1'b0;
      k_q        <= 8'h00;
      lfsr_s_q   <= 16'sd0;
      n_en_q     <= 1'b0;
      shift_q    <= 3'd0;
      s1_valid_q <= 1'b0;
      sine_q     <= 16'sd0;
      noise_q    <= 16'sd0;
      valid_q    <= 1'b0;
      out_q      <= 16'h0000;
    end else begin
      s0_valid_q <= bus.en;
      if (bus.en) begin
        phase_q  <= phase_q + bus.tone_fcw;
        lfsr_q   <= lfsr_next;
        k_q      <= phase_q[15:8];
        lfsr_s_q <= signed'(lfsr_q);
        n_en_q   <= bus.noise_en;
        shift_q  <= bus.noise_shift;
      end

      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        sine_q  <= sine_d;
        noise_q <= noise_d;
      end

      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= sat_d;
      end
    end
  end

  assign bus.signal_valid = valid_q;
  assign bus.noisy_signal = out_q;

endmodule

// File: tb/tb_noisy_sig_gen.sv
// Scoreboard bench for noisy_sig_gen: a real-valued sine/floor model predicts every sample.
module tb_noisy_sig_gen;

  logic clk = 1'b0;
  logic rst_n;

  noisy_sig_gen_if bus ();

  noisy_sig_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input logic [15:0] ph, input logic [15:0] lf,
                                               input logic ne, input logic [2:0] ns);
    real ang;
    int  s;
    int  n;
    int  total;
    ang = 2.0 * 3.141592653589793 * real'(int'(ph[15:8])) / 256.0;
    s   = int'(8192.0 * $sin(ang));
    n   = 0;
    if (ne) n = int'($floor(real'(int'($signed(lf))) / real'(1 << (2 + int'(ns)))));
    total = s + n;
    if (total > 32767)  total = 32767;
    if (total < -32768) total = -32768;
    return 16'(total);
  endfunction

  // Reference state, advanced only on en edges.
  logic [15:0] m_phase;
  logic [15:0] m_lfsr;
  logic [2:0]  vpipe;
  logic [15:0] exp_q[$];
  logic [15:0] got[$];
  logic [15:0] last_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 16'h0000;
      m_lfsr  <= 16'hACE1;
      vpipe   <= 3'b000;
      exp_q.delete();
    end else begin
      vpipe <= {vpipe[1:0], bus.en};
      if (bus.en) begin
        exp_q.push_back(model_sample(m_phase, m_lfsr, bus.noise_en, bus.noise_shift));
        m_phase <= m_phase + bus.tone_fcw;
        m_lfsr  <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_out <= 16'h0000;
    end else begin
      check_eq("valid", {31'd0, bus.signal_valid}, {31'd0, vpipe[2]});
      if (bus.signal_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_depth", exp_q.size(), 1);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check_eq("sample", {16'd0, bus.noisy_signal}, {16'd0, e});
          got.push_back(bus.noisy_signal);
          last_out <= e;
        end
      end else begin
        check_eq("hold", {16'd0, bus.noisy_signal}, {16'd0, last_out});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || vpipe != 3'b000) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) check_eq("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  logic [15:0] pat_a [4] = '{16'h0000, 16'h2000, 16'h0000, 16'hE000};

  initial begin
    int n_en;
    rst_n            = 1'b0;
    bus.en           = 1'b0;
    bus.tone_fcw     = 16'h0000;
    bus.noise_en     = 1'b0;
    bus.noise_shift  = 3'd0;
    #1;
    check_eq("rst_out", {16'd0, bus.noisy_signal}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.signal_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Quarter-turn tone, continuous en.
    do_reset();
    bus.tone_fcw = 16'h4000;
    bus.noise_en = 1'b0;
    bus.en       = 1'b1;
    @(negedge clk); check_eq("A_v_e1", {31'd0, bus.signal_valid}, 32'd0);
    @(negedge clk); check_eq("A_v_e2", {31'd0, bus.signal_valid}, 32'd0);
    @(negedge clk); check_eq("A_v_e3", {31'd0, bus.signal_valid}, 32'd1);
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    drain();
    check_eq("A_cnt", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check_eq("A_pat", {16'd0, got[i]}, {16'd0, pat_a[i % 4]});

    // 256-sample period tone.
    do_reset();
    bus.tone_fcw = 16'h0100;
    bus.en       = 1'b1;
    repeat (256) @(negedge clk);
    bus.en = 1'b0;
    drain();
    check_eq("B_cnt", got.size(), 256);
    if (got.size() == 256) begin
      check_eq("B_s0",   {16'd0, got[0]},   32'h0000);
      check_eq("B_s32",  {16'd0, got[32]},  32'd5793);
      check_eq("B_s64",  {16'd0, got[64]},  32'd8192);
      check_eq("B_s128", {16'd0, got[128]}, 32'h0000);
      check_eq("B_s192", {16'd0, got[192]}, 32'hE000);
    end

    // Noise only, then an asynchronous reset mid-stream.
    do_reset();
    bus.tone_fcw    = 16'h0000;
    bus.noise_en    = 1'b1;
    bus.noise_shift = 3'd0;
    bus.en          = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("C_rst_out", {16'd0, bus.noisy_signal}, 32'd0);
    check_eq("C_rst_valid", {31'd0, bus.signal_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    drain();
    check_eq("C_cnt", got.size(), 9);
    if (got.size() == 9) begin
      check_eq("C_s0",  {16'd0, got[0]}, 32'hEB38);
      check_eq("C_s1",  {16'd0, got[1]}, 32'hF89C);
      check_eq("C_r0",  {16'd0, got[4]}, 32'hEB38);
      check_eq("C_r1",  {16'd0, got[5]}, 32'hF89C);
    end

    // en gap of three cycles after sample 1.
    do_reset();
    bus.tone_fcw = 16'h4000;
    bus.noise_en = 1'b0;
    bus.en       = 1'b1;
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("D_gap_valid", {31'd0, bus.signal_valid}, 32'd0);
    check_eq("D_gap_hold", {16'd0, bus.noisy_signal}, 32'h2000);
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    drain();
    check_eq("D_cnt", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("D_pat", {16'd0, got[i]}, {16'd0, pat_a[i]});

    // Maximum noise attenuation.
    do_reset();
    bus.tone_fcw    = 16'h0000;
    bus.noise_en    = 1'b1;
    bus.noise_shift = 3'd7;
    bus.en          = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    drain();
    check_eq("E_cnt", got.size(), 1);
    if (got.size() == 1) check_eq("E_s0", {16'd0, got[0]}, 32'hFFD6);

    // Random controls changing every cycle with irregular en.
    do_reset();
    n_en = 0;
    for (int i = 0; i < 300; i++) begin
      bus.en          = 1'($urandom_range(0, 3) != 0);
      bus.tone_fcw    = 16'($urandom);
      bus.noise_en    = 1'($urandom_range(0, 1));
      bus.noise_shift = 3'($urandom_range(0, 7));
      if (bus.en) n_en++;
      @(negedge clk);
    end
    bus.en = 1'b0;
    drain();
    check_eq("F_cnt", got.size(), n_en);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
